dma8080: RTL and testbench

- Memory-to-memory DMA engine: a second bus initiator on the cpu8080 system bus.
- Responder side: the CPU programs it through an 8-register I/O window, matching the select unit's I/O register style.
- Initiator side: requests the bus (busreq/busack), then drives its own memory read and write cycles to copy a block (e.g. ROM to RAM).
- An external arbiter muxes maddr/mreadmem/mwritemem onto the system bus while busack is high.

---
 rtl/dma8080.sv | 200 ++++++++++++++++++++
 tb/tb_dma8080.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma8080.sv
// dma8080: memory-to-memory DMA engine, second initiator on the cpu8080 bus.
// Programmed through an 8-register I/O window, then copies a block by driving
// its own read/write cycles while the arbiter grants the bus.
module dma8080 #(
  parameter logic [7:0]  BASE  = 8'h10,
  parameter int unsigned RDLAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        readio,
  input  logic        writeio,
  output logic        busreq,
  input  logic        busack,
  output logic [15:0] maddr,
  output logic        mreadmem,
  output logic        mwritemem,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WaitW    = (RDLAT > 1) ? $clog2(RDLAT) : 1;
  localparam int unsigned LastWait = (RDLAT > 0) ? RDLAT - 1 : 0;

  typedef enum logic [2:0] {StIdle, StReq, StRd, StRdw, StWr, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic             hold_q, hold_d, done_q, done_d, abort_q, abort_d;
  logic [7:0]       byte_q, byte_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic       sel, reg_wr, reg_rd, busy_int, ctrl_wr, start_go, abort_now;
  logic [2:0] off;
  logic [7:0] rdata;
  logic       unused_addr;

  assign unused_addr = ^addr[15:8];
  assign off       = addr[2:0];
  assign sel       = (addr[7:3] == BASE[7:3]);
  assign reg_wr    = writeio & sel;
  assign reg_rd    = readio & sel;
  assign busy_int  = state_q inside {StReq, StRd, StRdw, StWr};
  assign ctrl_wr   = reg_wr && (off == 3'd6);
  assign start_go  = ctrl_wr && data[0] && !busy_int;
  // An abort written this very cycle already counts, so REQ exits at once.
  assign abort_now = abort_q || (ctrl_wr && data[7] && busy_int);

  // Next-state: CPU register writes, then the transfer sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = done_q;
    abort_d = abort_q;
    byte_d  = byte_q;
    wait_d  = wait_q;

    if (reg_wr && !busy_int) begin
      case (off)
        3'd0:    src_d[7:0]  = data;
        3'd1:    src_d[15:8] = data;
        3'd2:    dst_d[7:0]  = data;
        3'd3:    dst_d[15:8] = data;
        3'd4:    cnt_d[7:0]  = data;
        3'd5:    cnt_d[15:8] = data;
        default: ;
      endcase
    end
    if (ctrl_wr) begin
      hold_d = data[3];
      done_d = 1'b0;
      if (data[7] && busy_int) abort_d = 1'b1;
    end

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_go) begin
          if (cnt_q == 16'd0) done_d = 1'b1;
          else                state_d = StReq;
        end
      end
      StReq: begin
        if (abort_now)   state_d = StDone;
        else if (busack) state_d = StRd;
      end
      StRd: begin
        if (!busack) begin
          state_d = StReq;
        end else if (RDLAT == 0) begin
          byte_d  = data;
          state_d = StWr;
        end else begin
          wait_d  = '0;
          state_d = StRdw;
        end
      end
      StRdw: begin
        if (!busack) begin
          state_d = StReq;
        end else if (wait_q == WaitW'(LastWait)) begin
          byte_d  = data;
          state_d = StWr;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWr: begin
        if (!busack) begin
          state_d = StReq;
        end else begin
          cnt_d = cnt_q - 16'd1;
          dst_d = dst_q + 16'd1;
          if (!hold_q) src_d = src_q + 16'd1;
          state_d = ((cnt_q == 16'd1) || abort_now) ? StDone : StRd;
        end
      end
      default: state_d = StIdle;
    endcase

    // Entering DONE raises the sticky flag and retires any pending abort.
    if (state_d == StDone && state_q != StDone) begin
      done_d  = 1'b1;
      abort_d = 1'b0;
    end
  end

  // State and register file, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      byte_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
    end
  end

  // Bus strobes exist only while granted; losing busack drops them at once.
  always_comb begin
    maddr     = '0;
    mreadmem  = 1'b0;
    mwritemem = 1'b0;
    if (busack) begin
      case (state_q)
        StRd, StRdw: begin
          maddr    = src_q;
          mreadmem = 1'b1;
        end
        StWr: begin
          maddr     = dst_q;
          mwritemem = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register readback mux; pointers and count read live.
  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = src_q[7:0];
      3'd1:    rdata = src_q[15:8];
      3'd2:    rdata = dst_q[7:0];
      3'd3:    rdata = dst_q[15:8];
      3'd4:    rdata = cnt_q[7:0];
      3'd5:    rdata = cnt_q[15:8];
      3'd6:    rdata = {abort_q, 3'b000, hold_q, done_q, busy_int, 1'b0};
      default: rdata = '0;
    endcase
  end

  assign busreq = busy_int;
  assign busy   = busy_int;
  assign done   = done_q;

  // CPU register access owns the bus over a stray DMA write drive.
  assign data = reg_rd ? rdata :
                (mwritemem && !readio && !writeio) ? byte_q : 8'hzz;

endmodule

// File: tb/tb_dma8080.sv
// Bench for dma8080: directed scenarios plus randomized block copies with
// random grant drops, checked against an arithmetic model of the copy.
module tb_dma8080;
  localparam logic [7:0] BASE = 8'h10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0;
  wire  [7:0]  data;
  logic        readio = 1'b0, writeio = 1'b0, busack = 1'b0;
  logic        busreq, mreadmem, mwritemem, busy, done;
  logic [15:0] maddr;

  logic        cpu_en = 1'b0;
  logic [7:0]  cpu_dout = 8'h0;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ram_q = 8'h0;
  logic        ram_vld = 1'b0;
  logic        prev_rd = 1'b0;
  int          cyc = 0;
  int          overlap = 0;
  int          tests = 0, fails = 0;

  logic [23:0] wr_q[$];
  int          wr_cyc[$];
  logic [15:0] rd_q[$];
  logic [23:0] exp_q[$];

  dma8080 #(.BASE(BASE), .RDLAT(1)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data),
    .readio(readio), .writeio(writeio), .busreq(busreq), .busack(busack),
    .maddr(maddr), .mreadmem(mreadmem), .mwritemem(mwritemem),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  assign data = cpu_en ? cpu_dout : ((mreadmem && ram_vld) ? ram_q : 8'hzz);

  // Clocked RAM plus bus monitor; strobes seen at the edge that commits them.
  always @(posedge clock) begin
    ram_q   <= mem[maddr];
    ram_vld <= mreadmem;
    cyc     <= cyc + 1;
    prev_rd <= mreadmem;
    if (mreadmem && mwritemem) overlap <= overlap + 1;
    if (mwritemem) begin
      wr_q.push_back({maddr, data});
      wr_cyc.push_back(cyc);
      mem[maddr] = data;
    end
    if (mreadmem && !prev_rd) rd_q.push_back(maddr);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic io_wr(input logic [2:0] off, input logic [7:0] val);
    addr = {8'h00, BASE | {5'b0, off}};
    cpu_dout = val;
    cpu_en = 1'b1;
    writeio = 1'b1;
    step();
    writeio = 1'b0;
    cpu_en = 1'b0;
    addr = 16'h0;
  endtask

  task automatic io_rd(input logic [2:0] off, output logic [7:0] val);
    addr = {8'h00, BASE | {5'b0, off}};
    readio = 1'b1;
    #1;
    val = data;
    readio = 1'b0;
    addr = 16'h0;
    step();
  endtask

  task automatic rd16(input logic [2:0] off, output logic [15:0] v);
    logic [7:0] lo, hi;
    io_rd(off, lo);
    io_rd(off + 3'd1, hi);
    v = {hi, lo};
  endtask

  task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                      input logic [7:0] ctrl);
    io_wr(3'd0, s[7:0]);  io_wr(3'd1, s[15:8]);
    io_wr(3'd2, d[7:0]);  io_wr(3'd3, d[15:8]);
    io_wr(3'd4, n[7:0]);  io_wr(3'd5, n[15:8]);
    io_wr(3'd6, ctrl);
  endtask

  // Expected copy: byte i goes from src(+i unless hold) to dst+i, mod 2^16.
  task automatic build_exp(input logic [15:0] s, input logic [15:0] d, input int n,
                           input logic hold);
    logic [15:0] a, b;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = d + 16'(i);
      b = hold ? s : s + 16'(i);
      exp_q.push_back({a, mem[b]});
    end
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc.delete();
    rd_q.delete();
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!done && k < limit) begin
      step();
      k++;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic poll_wr(input string tag, input int n, input logic need_rd);
    int k = 0;
    while (!(wr_q.size() == n && (!need_rd || mreadmem)) && k < 300) begin
      step();
      k++;
    end
    check({tag, "_poll"}, {31'b0, k < 300}, 32'd1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {8'h0, wr_q[i]}, {8'h0, exp_q[i]});
  endtask

  initial begin
    logic [15:0] v16;
    logic [7:0]  v8;
    logic [15:0] s, d, n;
    logic        h;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    busack = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_busreq", {31'b0, busreq}, 0);
    check("rst_strobes", {30'b0, mreadmem, mwritemem}, 0);
    check("rst_maddr", {16'b0, maddr}, 0);
    check("rst_busy_done", {30'b0, busy, done}, 0);
    rd16(3'd0, v16); check("rst_src", {16'b0, v16}, 0);
    rd16(3'd4, v16); check("rst_cnt", {16'b0, v16}, 0);
    io_rd(3'd6, v8); check("rst_status", {24'b0, v8}, 0);

    // Basic 4-byte copy, grant tied high.
    build_exp(16'h0000, 16'h0400, 4, 1'b0);
    clear_logs();
    prog(16'h0000, 16'h0400, 16'h0004, 8'h01);
    check("t1_busreq_rise", {30'b0, busreq, busy}, 32'h3);
    wait_done("t1", 100);
    check_writes("t1");
    check("t1_nrd", rd_q.size(), 4);
    for (int i = 0; i < rd_q.size(); i++) check($sformatf("t1_rd%0d", i), {16'b0, rd_q[i]}, i);
    for (int i = 1; i < wr_cyc.size(); i++)
      check($sformatf("t1_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 3);
    check("t1_busreq_off", {31'b0, busreq}, 0);
    rd16(3'd4, v16); check("t1_cnt", {16'b0, v16}, 0);
    rd16(3'd0, v16); check("t1_src", {16'b0, v16}, 16'h0004);
    rd16(3'd2, v16); check("t1_dst", {16'b0, v16}, 16'h0404);
    io_rd(3'd6, v8); check("t1_status", {24'b0, v8}, 8'h04);
    io_rd(3'd7, v8); check("t1_off7", {24'b0, v8}, 0);

    // Zero-length start.
    clear_logs();
    prog(16'h0100, 16'h0500, 16'h0000, 8'h01);
    check("t2_done", {30'b0, done, busy}, 32'h2);
    check("t2_busreq", {31'b0, busreq}, 0);
    step(3);
    check("t2_nrd", rd_q.size(), 0);
    io_wr(3'd6, 8'h00);
    check("t2_clear", {31'b0, done}, 0);

    // Hold source.
    build_exp(16'h0042, 16'h2000, 3, 1'b1);
    clear_logs();
    prog(16'h0042, 16'h2000, 16'h0003, 8'h09);
    wait_done("t3", 100);
    check_writes("t3");
    for (int i = 0; i < rd_q.size(); i++) check($sformatf("t3_rd%0d", i), {16'b0, rd_q[i]}, 16'h0042);
    rd16(3'd0, v16); check("t3_src", {16'b0, v16}, 16'h0042);

    // Address wrap.
    build_exp(16'hFFFF, 16'hFFFE, 2, 1'b0);
    clear_logs();
    prog(16'hFFFF, 16'hFFFE, 16'h0002, 8'h01);
    wait_done("t4", 100);
    check_writes("t4");
    check("t4_rd1", {16'b0, (rd_q.size() > 1) ? rd_q[1] : 16'hDEAD}, 16'h0000);
    rd16(3'd0, v16); check("t4_src", {16'b0, v16}, 16'h0001);
    rd16(3'd2, v16); check("t4_dst", {16'b0, v16}, 16'h0000);

    // Grant loss during the second byte's read wait.
    build_exp(16'h1000, 16'h3000, 3, 1'b0);
    clear_logs();
    prog(16'h1000, 16'h3000, 16'h0003, 8'h01);
    poll_wr("t5", 1, 1'b1);
    step();
    check("t5_in_rdw", {31'b0, mreadmem}, 1);
    busack = 1'b0;
    #1;
    check("t5_drop", {14'b0, mreadmem, mwritemem, maddr}, 0);
    step();
    check("t5_busreq", {31'b0, busreq}, 1);
    rd16(3'd4, v16); check("t5_cnt", {16'b0, v16}, 16'h0002);
    busack = 1'b1;
    wait_done("t5", 100);
    check_writes("t5");
    check("t5_nrd", rd_q.size(), 4);

    // Abort while waiting for the grant.
    busack = 1'b0;
    prog(16'h1100, 16'h3100, 16'h0005, 8'h01);
    clear_logs();
    io_wr(3'd6, 8'h80);
    check("t6_state", {29'b0, done, busy, busreq}, 32'h4);
    io_rd(3'd6, v8); check("t6_status", {24'b0, v8}, 8'h04);
    rd16(3'd4, v16); check("t6_cnt", {16'b0, v16}, 16'h0005);
    check("t6_nrd", rd_q.size(), 0);
    busack = 1'b1;

    // Abort mid-block: issued during byte 3's read, so byte 3 still lands.
    build_exp(16'h1200, 16'h3200, 3, 1'b0);
    clear_logs();
    prog(16'h1200, 16'h3200, 16'h0008, 8'h01);
    poll_wr("t7", 2, 1'b0);
    io_wr(3'd6, 8'h80);
    wait_done("t7", 100);
    check_writes("t7");
    check("t7_busreq", {31'b0, busreq}, 0);
    rd16(3'd4, v16); check("t7_cnt", {16'b0, v16}, 16'h0005);
    rd16(3'd0, v16); check("t7_src", {16'b0, v16}, 16'h1203);

    // Reset during a write cycle.
    clear_logs();
    prog(16'h1300, 16'h3300, 16'h0004, 8'h01);
    begin
      int k = 0;
      while (!mwritemem && k < 50) begin step(); k++; end
      check("t8_reach_wr", {31'b0, mwritemem}, 1);
    end
    reset = 1'b1;
    step();
    check("t8_outs", {12'b0, busreq, mreadmem, mwritemem, busy, done, 15'b0, |maddr}, 0);
    reset = 1'b0;
    clear_logs();
    step(5);
    check("t8_nwr", wr_q.size(), 0);
    rd16(3'd4, v16); check("t8_cnt", {16'b0, v16}, 0);

    // Random copies with random grant drops.
    for (int t = 0; t < 4; t++) begin
      s = 16'($urandom);
      d = s ^ 16'h8000;
      n = 16'($urandom_range(1, 12));
      h = 1'($urandom);
      build_exp(s, d, int'(n), h);
      clear_logs();
      prog(s, d, n, {4'b0, h, 3'b001});
      begin
        int k = 0;
        while (!done && k < 3000) begin
          busack = ($urandom_range(0, 3) != 0);
          step();
          k++;
        end
      end
      busack = 1'b1;
      check($sformatf("r%0d_done", t), {31'b0, done}, 1);
      check_writes($sformatf("r%0d", t));
      rd16(3'd0, v16); check($sformatf("r%0d_src", t), {16'b0, v16}, {16'b0, h ? s : s + n});
      rd16(3'd2, v16); check($sformatf("r%0d_dst", t), {16'b0, v16}, {16'b0, d + n});
      rd16(3'd4, v16); check($sformatf("r%0d_cnt", t), {16'b0, v16}, 0);
    end

    check("no_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
